// File: rtl/ucode_sequencer.sv
// Microcoded control sequencer. It steps a T-state counter, forms the
// microcode ROM address {opcode, tstate} and registers the ROM word into the
// UIR. It decodes the UIR into bus strobes, ALU controls and jump-taken.
module ucode_sequencer #(
  parameter int OPCODE_W = 8,
  parameter int TSTATE_W = 3,
  parameter bit WAIT_EN  = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [OPCODE_W-1:0]          opcode,
  output logic [OPCODE_W+TSTATE_W-1:0] rom_addr,
  input  logic [15:0]                  rom_data,
  input  logic                         flag_z,
  input  logic                         flag_lt,
  input  logic                         flag_c,
  input  logic                         dev_wait,
  output logic [TSTATE_W-1:0]          tstate,
  output logic                         uir_valid,
  output logic                         EO,
  output logic [5:0]                   ALU_flags,
  output logic [7:0]                   bus_out_oh,
  output logic [7:0]                   bus_in_oh,
  output logic                         RT,
  output logic                         PA,
  output logic                         jump_taken,
  output logic                         stall
);

  logic [15:0]         uir_q, uir_d;
  logic [TSTATE_W-1:0] tstate_q, tstate_d;
  logic                valid_q, valid_d;

  assign rom_addr  = {opcode, tstate_q};
  assign tstate    = tstate_q;
  assign uir_valid = valid_q;

  // Decode the UIR into strobes; everything is forced low while the UIR is idle.
  always_comb begin
    bus_out_oh = '0;
    bus_in_oh  = '0;
    if (valid_q && !uir_q[15]) begin
      bus_out_oh[uir_q[14:12]] = 1'b1;
    end
    if (valid_q && (uir_q[8:6] != 3'd0)) begin
      bus_in_oh[uir_q[8:6]] = 1'b1;
    end
    EO         = valid_q & uir_q[15];
    ALU_flags  = valid_q ? uir_q[14:9] : '0;
    RT         = valid_q & ~uir_q[15] & uir_q[11];
    PA         = valid_q & ~uir_q[15] & uir_q[10];
    jump_taken = valid_q & ((uir_q[5] & flag_c) |
                            (uir_q[4] & flag_z) |
                            (uir_q[3] & ~flag_z & ~flag_lt) |
                            (uir_q[2] & flag_lt));
    stall      = WAIT_EN & dev_wait & (bus_out_oh[6] | bus_in_oh[6]);
  end

  // Next-state: hold on stall, the end marker wins over RT, and RT wins over increment.
  always_comb begin
    uir_d    = uir_q;
    tstate_d = tstate_q;
    valid_d  = valid_q;
    if (!stall) begin
      if (rom_data == 16'h0000) begin
        uir_d    = '0;
        valid_d  = 1'b0;
        tstate_d = '0;
      end else begin
        uir_d    = rom_data;
        valid_d  = 1'b1;
        tstate_d = RT ? '0 : tstate_q + TSTATE_W'(1);
      end
    end
  end

  // State registers with asynchronous reset to the idle, invalid-UIR state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      uir_q    <= '0;
      tstate_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      uir_q    <= uir_d;
      tstate_q <= tstate_d;
      valid_q  <= valid_d;
    end
  end

endmodule

// File: tb/tb_ucode_sequencer.sv
// Directed bench for ucode_sequencer: default instance, a WAIT_EN=0 instance
// and a TSTATE_W=2 instance, each fed from a ROM array indexed by rom_addr.
module tb_ucode_sequencer;

  logic clk = 1'b0;
  logic reset, rst2;
  logic [7:0] opcode, opcode2;
  logic flag_z, flag_lt, flag_c, dev_wait;

  logic [15:0] rom  [0:2047];
  logic [15:0] rom2 [0:1023];

  // main instance
  logic [10:0] m_addr;
  logic [15:0] m_data;
  logic [2:0]  m_ts;
  logic        m_valid, m_eo, m_rt, m_pa, m_jt, m_stall;
  logic [5:0]  m_alu;
  logic [7:0]  m_bo, m_bi;

  // WAIT_EN=0 instance
  logic [10:0] n_addr;
  logic [15:0] n_data;
  logic [2:0]  n_ts;
  logic        n_valid, n_eo, n_rt, n_pa, n_jt, n_stall;
  logic [5:0]  n_alu;
  logic [7:0]  n_bo, n_bi;

  // TSTATE_W=2 instance
  logic [9:0]  t_addr;
  logic [15:0] t_data;
  logic [1:0]  t_ts;
  logic        t_valid, t_eo, t_rt, t_pa, t_jt, t_stall;
  logic [5:0]  t_alu;
  logic [7:0]  t_bo, t_bi;

  assign m_data = rom[m_addr];
  assign n_data = rom[n_addr];
  assign t_data = rom2[t_addr];

  always #5 clk = ~clk;

  ucode_sequencer dut (
    .clk(clk), .reset(reset), .opcode(opcode), .rom_addr(m_addr), .rom_data(m_data),
    .flag_z(flag_z), .flag_lt(flag_lt), .flag_c(flag_c), .dev_wait(dev_wait),
    .tstate(m_ts), .uir_valid(m_valid), .EO(m_eo), .ALU_flags(m_alu),
    .bus_out_oh(m_bo), .bus_in_oh(m_bi), .RT(m_rt), .PA(m_pa),
    .jump_taken(m_jt), .stall(m_stall)
  );

  ucode_sequencer #(.WAIT_EN(1'b0)) dut_nw (
    .clk(clk), .reset(reset), .opcode(opcode), .rom_addr(n_addr), .rom_data(n_data),
    .flag_z(flag_z), .flag_lt(flag_lt), .flag_c(flag_c), .dev_wait(dev_wait),
    .tstate(n_ts), .uir_valid(n_valid), .EO(n_eo), .ALU_flags(n_alu),
    .bus_out_oh(n_bo), .bus_in_oh(n_bi), .RT(n_rt), .PA(n_pa),
    .jump_taken(n_jt), .stall(n_stall)
  );

  ucode_sequencer #(.TSTATE_W(2)) dut_t2 (
    .clk(clk), .reset(rst2), .opcode(opcode2), .rom_addr(t_addr), .rom_data(t_data),
    .flag_z(flag_z), .flag_lt(flag_lt), .flag_c(flag_c), .dev_wait(dev_wait),
    .tstate(t_ts), .uir_valid(t_valid), .EO(t_eo), .ALU_flags(t_alu),
    .bus_out_oh(t_bo), .bus_in_oh(t_bi), .RT(t_rt), .PA(t_pa),
    .jump_taken(t_jt), .stall(t_stall)
  );

  int passed = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; rst2 = 1'b1;
    opcode = 8'h00; opcode2 = 8'h05;
    flag_z = 1'b0; flag_lt = 1'b0; flag_c = 1'b0; dev_wait = 1'b0;
    for (int i = 0; i < 2048; i++) rom[i] = 16'h0000;
    for (int i = 0; i < 1024; i++) rom2[i] = 16'h0000;
    // opcode 0: PO/MI, ALU word, DO, end
    rom[{8'h00, 3'd0}] = 16'h0040;
    rom[{8'h00, 3'd1}] = 16'hFE00;
    rom[{8'h00, 3'd2}] = 16'h6000;
    // opcode 1: JZ, JGT, RT+PA, filler
    rom[{8'h01, 3'd0}] = 16'h0010;
    rom[{8'h01, 3'd1}] = 16'h0008;
    rom[{8'h01, 3'd2}] = 16'h0C00;
    rom[{8'h01, 3'd3}] = 16'h0001;
    // opcode 2: RT word followed by end marker
    rom[{8'h02, 3'd0}] = 16'h0800;
    // opcode 3: PO with DI load
    rom[{8'h03, 3'd0}] = 16'h0180;
    for (int i = 0; i < 4; i++) rom2[{8'h05, i[1:0]}] = 16'h0001;
    rom2[{8'h06, 2'd0}] = 16'h0800;
    for (int i = 1; i < 4; i++) rom2[{8'h06, i[1:0]}] = 16'h0001;

    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_valid",  m_valid, 0);
    chk("rst_bo",     m_bo, 0);
    chk("rst_bi",     m_bi, 0);
    chk("rst_eo",     m_eo, 0);
    chk("rst_alu",    m_alu, 0);
    chk("rst_ts",     m_ts, 0);
    chk("rst_addr",   m_addr, 0);

    tick();
    chk("c1_bo",    m_bo, 8'h01);
    chk("c1_bi",    m_bi, 8'h02);
    chk("c1_ts",    m_ts, 1);
    chk("c1_valid", m_valid, 1);

    tick();
    chk("alu_eo",  m_eo, 1);
    chk("alu_fl",  m_alu, 6'h3F);
    chk("alu_bo",  m_bo, 0);
    chk("alu_bi",  m_bi, 0);
    chk("alu_rt",  m_rt, 0);
    chk("alu_pa",  m_pa, 0);

    tick();
    chk("do_bo", m_bo, 8'h40);
    chk("do_ts", m_ts, 3);
    dev_wait = 1'b1;
    #1;
    chk("st0_stall", m_stall, 1);
    chk("nw_stall",  n_stall, 0);
    tick();
    chk("st1_stall", m_stall, 1);
    chk("st1_ts",    m_ts, 3);
    chk("nw_ts",     n_ts, 0);
    chk("nw_valid",  n_valid, 0);
    tick();
    chk("st2_stall", m_stall, 1);
    chk("st2_ts",    m_ts, 3);
    chk("st2_bo",    m_bo, 8'h40);
    dev_wait = 1'b0;
    #1;
    chk("st_rel", m_stall, 0);

    tick();
    chk("end_valid", m_valid, 0);
    chk("end_ts",    m_ts, 0);
    chk("end_bo",    m_bo, 0);
    chk("end_bi",    m_bi, 0);
    chk("end_addr",  m_addr, 11'h000);
    opcode = 8'h01;

    tick();
    chk("jz_ts", m_ts, 1);
    flag_z = 1'b1; #1;
    chk("jz_z1", m_jt, 1);
    flag_z = 1'b0; #1;
    chk("jz_z0", m_jt, 0);

    tick();
    chk("jgt_00", m_jt, 1);
    flag_lt = 1'b1; #1;
    chk("jgt_lt", m_jt, 0);
    flag_lt = 1'b0;

    tick();
    chk("rt_ts", m_ts, 3);
    chk("rt_rt", m_rt, 1);
    chk("rt_pa", m_pa, 1);
    chk("rt_bo", m_bo, 8'h01);

    tick();
    chk("rt_next_ts",    m_ts, 0);
    chk("rt_next_valid", m_valid, 1);
    opcode = 8'h02;
    #1;
    chk("op2_addr", m_addr, {8'h02, 3'd0});

    tick();
    chk("op2_ts", m_ts, 1);
    chk("op2_rt", m_rt, 1);
    tick();
    chk("endrt_ts",    m_ts, 0);
    chk("endrt_valid", m_valid, 0);

    opcode = 8'h03;
    dev_wait = 1'b1;
    tick();
    chk("di_bi",    m_bi, 8'h40);
    chk("di_stall", m_stall, 1);
    tick();
    chk("di_ts", m_ts, 1);
    #2 reset = 1'b1;
    #1;
    chk("mid_valid", m_valid, 0);
    chk("mid_stall", m_stall, 0);
    chk("mid_ts",    m_ts, 0);
    chk("mid_bi",    m_bi, 0);
    dev_wait = 1'b0;

    @(negedge clk);
    rst2 = 1'b0;
    #1;
    chk("t2_ts0", t_ts, 0);
    tick(); chk("t2_ts1", t_ts, 1);
    tick(); chk("t2_ts2", t_ts, 2);
    tick(); chk("t2_ts3", t_ts, 3);
    tick(); chk("t2_wrap", t_ts, 0);
    chk("t2_wrap_valid", t_valid, 1);
    opcode2 = 8'h06;
    tick();
    chk("t2_rt_ts", t_ts, 1);
    chk("t2_rt",    t_rt, 1);
    tick();
    chk("t2_rt_next", t_ts, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
